// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Halt-word detection is enabled by defining FETCH_HALT_DETECT_EN.
package fetch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam word_t HALT_WORD = 32'h0;
  localparam word_t PC_STEP   = 32'd4;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t align_pc(word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction memory, redirect and decode handshake.
// The master side is the fetch unit; the slave side is its environment.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  word_t imem_addr;
  word_t imem_rdata;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  instr_valid;
  logic  instr_ready;
  word_t instr;
  word_t instr_pc;
  logic  halted;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  halted
  );

endinterface

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, instr} pairs; head is read straight from
// storage registers so no memory data reaches the outputs combinationally.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  fetch_entry_t  mem_q [DEPTH];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q
            + {{AW{1'b0}}, push_i}
            - {{AW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // On a full push+pop the write slot is the head being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: PC, RUN/HALTED state, push/redirect control.
// Define FETCH_HALT_DETECT_EN to stop fetch on an all-zero word.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 2
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_unit_if.master bus
);

  word_t        pc_q, pc_d;
  fetch_state_e state_q, state_d;
  fetch_entry_t head, wdata;
  logic         push, pop, full, empty;
  logic         room, halt_hit;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = bus.imem_rdata == HALT_WORD;
`else
  assign halt_hit = 1'b0;
`endif

  assign pop  = !empty && bus.instr_ready;
  assign room = !full || pop;

  assign wdata.pc    = pc_q;
  assign wdata.instr = bus.imem_rdata;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (bus.redirect_valid) begin
      pc_d    = align_pc(bus.redirect_pc);
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (room && halt_hit) begin
            state_d = HALTED;
          end else if (room) begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
          end
        end
        HALTED: ;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= align_pc(RESET_PC);
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(bus.redirect_valid),
    .wdata_i(wdata),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted = state_q == HALTED;
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based model.
// Works with or without FETCH_HALT_DETECT_EN.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int    DEPTH  = 2;
  localparam word_t RST_PC = 32'h0;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam word_t WA = 32'h1111_0001;
  localparam word_t WB = 32'h2222_0002;
  localparam word_t WC = 32'h3333_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic word_t rom(word_t a);
    case (a)
      32'h0:   return WA;
      32'h4:   return WB;
      32'h8:   return WC;
      32'hC:   return 32'h0;
      default: return a ^ 32'h9E37_79B9;
    endcase
  endfunction

  always_comb bus.imem_rdata = rom(bus.imem_addr);

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] mq[$];
  word_t       mpc;
  bit          mhalt;

  task automatic chk(string nm, word_t act, word_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = RST_PC;
    mhalt = 1'b0;
  endtask

  task automatic compare();
    logic [63:0] h;
    chk("instr_valid", 32'(bus.instr_valid),
        32'(mq.size() != 0));
    chk("imem_addr", bus.imem_addr, mpc);
    chk("halted", 32'(bus.halted), 32'(mhalt));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("instr_pc", bus.instr_pc, h[63:32]);
      chk("instr", bus.instr, h[31:0]);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(bit rdy, bit rv, word_t rpc);
    word_t       w;
    bit          pop;
    int          sz;
    logic [63:0] d;
    compare();
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    w   = rom(mpc);
    sz  = mq.size();
    pop = (sz != 0) && rdy;
    if (rv) begin
      mq.delete();
      mpc   = {rpc[31:2], 2'b00};
      mhalt = 1'b0;
    end else begin
      if (pop) d = mq.pop_front();
      if (!mhalt && (sz < DEPTH || pop)) begin
        if (HALT_EN && w == HALT_WORD) begin
          mhalt = 1'b1;
        end else begin
          mq.push_back({mpc, w});
          mpc = mpc + PC_STEP;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    model_reset();
    bus.redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit    rdy, rv;
    word_t rpc;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // Reset release with ready high: A, B, C back to back
    cycle(1, 0, 0);
    chk("seq0_pc", bus.instr_pc, 32'h0);
    chk("seq0_in", bus.instr, WA);
    cycle(1, 0, 0);
    chk("seq1_pc", bus.instr_pc, 32'h4);
    chk("seq1_in", bus.instr, WB);
    cycle(1, 0, 0);
    chk("seq2_pc", bus.instr_pc, 32'h8);
    chk("seq2_in", bus.instr, WC);
    cycle(1, 0, 0);
`ifdef FETCH_HALT_DETECT_EN
    chk("halt_flag", 32'(bus.halted), 32'h1);
    chk("halt_addr", bus.imem_addr, 32'hC);
    chk("halt_valid", 32'(bus.instr_valid), 32'h0);
    cycle(1, 0, 0);
    chk("halt_hold", bus.imem_addr, 32'hC);
    cycle(1, 1, 32'h0);
    chk("halt_clr", 32'(bus.halted), 32'h0);
    cycle(1, 0, 0);
    chk("resume_pc", bus.instr_pc, 32'h0);
`else
    chk("zero_pc", bus.instr_pc, 32'hC);
    chk("zero_in", bus.instr, 32'h0);
    chk("zero_halt", 32'(bus.halted), 32'h0);
`endif

    // Back-pressure: buffer fills, pc holds at 8
    pulse_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    chk("stall_addr", bus.imem_addr, 32'h8);
    chk("stall_pc", bus.instr_pc, 32'h0);
    cycle(1, 0, 0);
    chk("rel_pc", bus.instr_pc, 32'h4);
    chk("rel_in", bus.instr, WB);

    // Redirect with two entries buffered, unaligned target
    pulse_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 32'h0000_0013);
    chk("rd_flush", 32'(bus.instr_valid), 32'h0);
    chk("rd_addr", bus.imem_addr, 32'h10);
    cycle(1, 0, 0);
    chk("rd_pc", bus.instr_pc, 32'h10);

    // Wrap-around at the top of the address space
    cycle(1, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    chk("wrap0", bus.instr_pc, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    chk("wrap1", bus.instr_pc, 32'h0);
    chk("wrap1_in", bus.instr, WA);

    // Mid-stream reset is checked inside pulse_reset
    cycle(1, 0, 0);
    pulse_reset();
    cycle(1, 0, 0);
    chk("rst_restart", bus.instr_pc, RST_PC);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset();
      end else begin
        rdy = $urandom_range(0, 9) < 7;
        rv  = $urandom_range(0, 19) == 0;
        case ($urandom_range(0, 3))
          0: rpc = 32'($urandom_range(0, 7) * 4
                   + $urandom_range(0, 3));
          1: rpc = 32'hFFFF_FFF0
                   + 32'($urandom_range(0, 15));
          default: rpc = $urandom;
        endcase
        cycle(rdy, rv, rpc);
      end
    end
    compare();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch initiator paired with the combinational instruction ROM: owns the program counter, drives the word-aligned fetch address, captures the returned instruction word the same cycle, and queues {pc, instr} pairs in a small prefetch buffer toward decode over a valid/ready handshake. Sits between the instruction memory and the decode stage. Accepts a branch/exception redirect that flushes the buffer and restarts fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  fetch byte address; always equal to the PC register, bits [1:0] always 0.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  load new PC and flush the buffer.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  buffer head is valid.
- instr_ready  in  1  decode accepts the head.
- instr  out  32  head instruction word.
- instr_pc  out  32  address of the head instruction.
- halted  out  1  fetch stopped on a halt word. Tied to 0 when the halt feature is compiled out.

## Operation
- Reset: pc = RESET_PC, buffer empty, instr_valid = 0, instr = 0, instr_pc = 0, halted = 0, state RUN.
- States: RUN and HALTED. HALTED exists only with the configuration macro defined.
- Push condition: state RUN, no redirect, and the buffer is not full or a pop occurs in the same cycle.
- Push action: write {pc, imem_rdata} to the buffer tail and set pc = pc + 4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Pop: instr_valid && instr_ready removes the head.
- instr_valid, instr and instr_pc come directly from buffer registers. There is no combinational path from imem_rdata to the outputs.
- Full buffer with no pop: pc holds and imem_addr is stable.
- Redirect:
  - The buffer is flushed and pc = {redirect_pc[31:2], 2'b00}.
  - No push occurs that cycle; the state returns to RUN.
  - A redirect overrides any push in the same cycle.
  - A pop in the same cycle still counts as a completed handshake.
- Simultaneous push and pop on a full buffer: occupancy is unchanged and the ordering is preserved.
- Asserting rst_n low mid-operation clears the state immediately, without waiting for a clock edge.

## Timing
- After rst_n is released, the first push happens at the first rising edge, and instr_valid is 1 from that edge onward.
- Redirect asserted in cycle N: imem_addr equals the target during cycle N+1, and the target instruction is at the head with instr_valid = 1 from the edge ending N+1.
- With instr_ready held at 1 and no redirect, throughput is one instruction per cycle.
- Once full, the buffer refills one entry per cycle after pops resume.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - In RUN, a fetched word equal to 32'h0000_0000 is not pushed.
  - pc holds at the halt word's address, the state goes to HALTED, and halted = 1 from the next edge.
  - Entries already in the buffer still drain.
  - Only a redirect or a reset leaves HALTED.
- FETCH_HALT_DETECT_EN undefined: the zero word is pushed like any other instruction, and halted is constant 0.

## Structure
- Package fetch_pkg holds:
  - word_t (32-bit logic typedef).
  - fetch_state_e (RUN, HALTED).
  - HALT_WORD = 32'h0.
  - PC_STEP = 4.
- Sub-module fetch_buffer: a synchronous FIFO of DEPTH entries of {pc, instr}, with push, pop, flush, full and empty signals. It uses the same clk and rst_n.
- The top level contains the PC register, the state register and the push/redirect control.

## Test plan
- Reset release with ROM words A,B,C at addresses 0,4,8 and instr_ready = 1 → instr/instr_pc sequence (A,0), (B,4), (C,8) on consecutive cycles.
- instr_ready = 0 for 5 cycles → after 2 pushes, imem_addr holds at 8. On release, (A,0) is followed by (B,4) with no loss or duplication.
- redirect_valid with redirect_pc = 32'h0000_0013 while the buffer holds 2 entries → buffer flushed, next head is instr_pc = 32'h10 after 2 edges, and the stale entries are never seen.
- Redirect to 32'hFFFF_FFFC → next instr_pc values are FFFF_FFFC, then 0000_0000.
- With FETCH_HALT_DETECT_EN, a zero word at address 12 → words at 0,4,8 are delivered, halted = 1 and imem_addr holds at 12. A redirect to 0 clears halted and fetch resumes. Without the macro, the zero word is delivered with instr_pc = 12.
- rst_n pulsed low mid-stream → instr_valid drops immediately, and after release fetch restarts at RESET_PC.
